// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if
// Bundles the decode-side inputs and the execute-side outputs of the ID/EX
// pipeline register.
//   slave  : seen by the pipeline register (takes *_i, drives *_o)
//   master : seen by the surrounding pipeline (drives *_i, takes *_o)
// Signal groups:
//   stall_i / flush_i / valid_i    pipeline control from later stages and ID
//   control bits + aluop           WB/MEM/EX control from the control unit
//   pc_plus4 / dato1 / dato2 / signext   datapath operands
//   rs / rt / rd / funct           instruction fields
//   hazard_stall_o                 load-use stall request (combinational)
//   bubble_cnt_o                   saturating count of flush/hazard bubbles
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 16
);
  logic               stall_i;
  logic               flush_i;
  logic               valid_i;
  logic               br_en_i;
  logic               mem_to_br_i;
  logic               branch_i;
  logic               memw_i;
  logic               memr_i;
  logic               regdst_i;
  logic               alusrc_i;
  logic [ALUOP_W-1:0] aluop_i;
  logic [DATA_W-1:0]  pc_plus4_i;
  logic [DATA_W-1:0]  dato1_i;
  logic [DATA_W-1:0]  dato2_i;
  logic [DATA_W-1:0]  signext_i;
  logic [REG_W-1:0]   rs_i;
  logic [REG_W-1:0]   rt_i;
  logic [REG_W-1:0]   rd_i;
  logic [FUNCT_W-1:0] funct_i;

  logic               valid_o;
  logic               br_en_o;
  logic               mem_to_br_o;
  logic               branch_o;
  logic               memw_o;
  logic               memr_o;
  logic               regdst_o;
  logic               alusrc_o;
  logic [ALUOP_W-1:0] aluop_o;
  logic [DATA_W-1:0]  pc_plus4_o;
  logic [DATA_W-1:0]  dato1_o;
  logic [DATA_W-1:0]  dato2_o;
  logic [DATA_W-1:0]  signext_o;
  logic [REG_W-1:0]   rs_o;
  logic [REG_W-1:0]   rt_o;
  logic [REG_W-1:0]   rd_o;
  logic [FUNCT_W-1:0] funct_o;
  logic               hazard_stall_o;
  logic [CNT_W-1:0]   bubble_cnt_o;

  modport slave (
    input  stall_i, flush_i, valid_i,
    input  br_en_i, mem_to_br_i, branch_i, memw_i, memr_i, regdst_i, alusrc_i, aluop_i,
    input  pc_plus4_i, dato1_i, dato2_i, signext_i, rs_i, rt_i, rd_i, funct_i,
    output valid_o,
    output br_en_o, mem_to_br_o, branch_o, memw_o, memr_o, regdst_o, alusrc_o, aluop_o,
    output pc_plus4_o, dato1_o, dato2_o, signext_o, rs_o, rt_o, rd_o, funct_o,
    output hazard_stall_o, bubble_cnt_o
  );

  modport master (
    output stall_i, flush_i, valid_i,
    output br_en_i, mem_to_br_i, branch_i, memw_i, memr_i, regdst_i, alusrc_i, aluop_i,
    output pc_plus4_i, dato1_i, dato2_i, signext_i, rs_i, rt_i, rd_i, funct_i,
    input  valid_o,
    input  br_en_o, mem_to_br_o, branch_o, memw_o, memr_o, regdst_o, alusrc_o, aluop_o,
    input  pc_plus4_o, dato1_o, dato2_o, signext_o, rs_o, rt_o, rd_o, funct_o,
    input  hazard_stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg
// ID/EX pipeline register of the 5-stage MIPS core with valid tracking,
// freeze, branch flush, load-use hazard detection with bubble insertion and
// a saturating bubble counter.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears every register
//   bus      id_ex_pipe_reg_if.slave (decode inputs, execute outputs,
//            hazard_stall_o, bubble_cnt_o)
// Update priority on each edge: stall (hold) > flush (counted bubble) >
// load-use hazard (counted bubble) > empty ID slot (uncounted bubble) > load.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  id_ex_pipe_reg_if.slave bus
);

  logic               valid_r;
  logic               br_en_r;
  logic               mem_to_br_r;
  logic               branch_r;
  logic               memw_r;
  logic               memr_r;
  logic               regdst_r;
  logic               alusrc_r;
  logic [ALUOP_W-1:0] aluop_r;
  logic [DATA_W-1:0]  pc_plus4_r;
  logic [DATA_W-1:0]  dato1_r;
  logic [DATA_W-1:0]  dato2_r;
  logic [DATA_W-1:0]  signext_r;
  logic [REG_W-1:0]   rs_r;
  logic [REG_W-1:0]   rt_r;
  logic [REG_W-1:0]   rd_r;
  logic [FUNCT_W-1:0] funct_r;
  logic [CNT_W-1:0]   cnt_r;

  logic hazard_s;
  logic load_s;
  logic bubble_s;
  logic count_s;
  logic cnt_inc_s;

  // A valid load in EX whose non-zero rt is a source of the valid ID
  // instruction; a flush already kills the ID instruction so it cannot stall.
  assign hazard_s = valid_r & memr_r & (rt_r != {REG_W{1'b0}}) & bus.valid_i &
                    ((rt_r == bus.rs_i) | (rt_r == bus.rt_i)) & ~bus.flush_i;

  // Saturate instead of wrapping so the monitor never under-reports.
  assign cnt_inc_s = count_s & (cnt_r != {CNT_W{1'b1}});

  // Decide what the register does on the coming edge.
  always_comb begin
    load_s   = 1'b0;
    bubble_s = 1'b0;
    count_s  = 1'b0;
    if (bus.stall_i) begin
      load_s   = 1'b0;
      bubble_s = 1'b0;
    end else if (bus.flush_i) begin
      bubble_s = 1'b1;
      count_s  = 1'b1;
    end else if (hazard_s) begin
      bubble_s = 1'b1;
      count_s  = 1'b1;
    end else if (!bus.valid_i) begin
      bubble_s = 1'b1;
    end else begin
      load_s = 1'b1;
    end
  end

  // Control and valid bits: loaded from ID or zeroed on a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r     <= 1'b0;
      br_en_r     <= 1'b0;
      mem_to_br_r <= 1'b0;
      branch_r    <= 1'b0;
      memw_r      <= 1'b0;
      memr_r      <= 1'b0;
      regdst_r    <= 1'b0;
      alusrc_r    <= 1'b0;
      aluop_r     <= {ALUOP_W{1'b0}};
    end else if (load_s) begin
      valid_r     <= 1'b1;
      br_en_r     <= bus.br_en_i;
      mem_to_br_r <= bus.mem_to_br_i;
      branch_r    <= bus.branch_i;
      memw_r      <= bus.memw_i;
      memr_r      <= bus.memr_i;
      regdst_r    <= bus.regdst_i;
      alusrc_r    <= bus.alusrc_i;
      aluop_r     <= bus.aluop_i;
    end else if (bubble_s) begin
      valid_r     <= 1'b0;
      br_en_r     <= 1'b0;
      mem_to_br_r <= 1'b0;
      branch_r    <= 1'b0;
      memw_r      <= 1'b0;
      memr_r      <= 1'b0;
      regdst_r    <= 1'b0;
      alusrc_r    <= 1'b0;
      aluop_r     <= {ALUOP_W{1'b0}};
    end
  end

  // Datapath and register fields: only a real load changes them; bubbles
  // leave them untouched since a cleared valid bit already neutralises them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_plus4_r <= {DATA_W{1'b0}};
      dato1_r    <= {DATA_W{1'b0}};
      dato2_r    <= {DATA_W{1'b0}};
      signext_r  <= {DATA_W{1'b0}};
      rs_r       <= {REG_W{1'b0}};
      rt_r       <= {REG_W{1'b0}};
      rd_r       <= {REG_W{1'b0}};
      funct_r    <= {FUNCT_W{1'b0}};
    end else if (load_s) begin
      pc_plus4_r <= bus.pc_plus4_i;
      dato1_r    <= bus.dato1_i;
      dato2_r    <= bus.dato2_i;
      signext_r  <= bus.signext_i;
      rs_r       <= bus.rs_i;
      rt_r       <= bus.rt_i;
      rd_r       <= bus.rd_i;
      funct_r    <= bus.funct_i;
    end
  end

  // Bubble counter for flush and hazard bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.valid_o        = valid_r;
  assign bus.br_en_o        = br_en_r;
  assign bus.mem_to_br_o    = mem_to_br_r;
  assign bus.branch_o       = branch_r;
  assign bus.memw_o         = memw_r;
  assign bus.memr_o         = memr_r;
  assign bus.regdst_o       = regdst_r;
  assign bus.alusrc_o       = alusrc_r;
  assign bus.aluop_o        = aluop_r;
  assign bus.pc_plus4_o     = pc_plus4_r;
  assign bus.dato1_o        = dato1_r;
  assign bus.dato2_o        = dato2_r;
  assign bus.signext_o      = signext_r;
  assign bus.rs_o           = rs_r;
  assign bus.rt_o           = rt_r;
  assign bus.rd_o           = rd_r;
  assign bus.funct_o        = funct_r;
  assign bus.hazard_stall_o = hazard_s;
  assign bus.bubble_cnt_o   = cnt_r;

endmodule
